// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single fixed-latency memory port (fetch vs. load/store).
// Define MEM_PORT_ARBITER_ROUND_ROBIN_EN to alternate ties instead of favouring port 1.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          sel,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          winner;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    logic          last_grant_q, last_grant_d;

    // A tie goes to whichever port was not granted last.
    assign winner = (req0 && req1) ? ~last_grant_q : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (req0 || req1)) last_grant_d = winner;
    end
`else
    assign winner = req1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields are latched only on the IDLE->ACCESS edge, so they stay frozen until the next grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        mem_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = winner;
                    we_d    = winner ? we1    : we0;
                    addr_d  = winner ? addr1  : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_en  = 1'b1;
                gnt0    = ~sel_q;
                gnt1    = sel_q;
                cnt_d   = 4'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                ack0    = ~sel_q;
                ack1    = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel       = sel_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Expected grant order follows MEM_PORT_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, ack0, ack1, sel, memEn, memWe;
    logic [15:0] rdata, memAddr, memWdata, memRdata;

    logic        bReq1, bWe1;
    logic [15:0] bAddr1, bWdata1;
    logic        bGnt0, bGnt1, bAck0, bAck1, bSel, bMemEn, bMemWe;
    logic [15:0] bRdata, bMemAddr, bMemWdata, bMemRdata;

    int total = 0;
    int bad = 0;
    int firstWin;
    int p;
    int rrExp[4];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) dutA (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .sel(sel), .mem_en(memEn), .mem_we(memWe),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) dutB (
        .clk(clk), .rst_n(rst_n),
        .req0(1'b0), .we0(1'b0), .addr0(16'h0000), .wdata0(16'h0000),
        .req1(bReq1), .we1(bWe1), .addr1(bAddr1), .wdata1(bWdata1),
        .gnt0(bGnt0), .gnt1(bGnt1), .ack0(bAck0), .ack1(bAck1),
        .rdata(bRdata), .sel(bSel), .mem_en(bMemEn), .mem_we(bMemWe),
        .mem_addr(bMemAddr), .mem_wdata(bMemWdata), .mem_rdata(bMemRdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        if (port == 0) begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end
    endtask

    // Waits a bounded number of cycles for a gnt (which=0) or ack (which=1) on dutA.
    task automatic waitFor(input string tag, input int which, output int port);
        port = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (which == 0 && (gnt0 || gnt1)) begin
                port = gnt1 ? 1 : 0;
                break;
            end
            if (which == 1 && (ack0 || ack1)) begin
                port = ack1 ? 1 : 0;
                break;
            end
        end
        if (port < 0) checkOutput(tag, 32'd1, 32'd0);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
        bReq1 = 1'b0; bWe1 = 1'b0; bAddr1 = 16'h0; bWdata1 = 16'h0;
        memRdata = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("exclusiveA", {gnt0 & gnt1, ack0 & ack1}, 32'd0);
            checkOutput("exclusiveB", {bGnt0 & bGnt1, bAck0 & bAck1}, 32'd0);
        end
    end

    initial begin
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        firstWin = 0;
        rrExp = '{0, 1, 0, 1};
`else
        firstWin = 1;
        rrExp = '{1, 1, 1, 1};
`endif
        bMemRdata = 16'hDEAD;
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
        bReq1 = 1'b0; bWe1 = 1'b0; bAddr1 = 16'h0; bWdata1 = 16'h0;
        memRdata = 16'h1111;
        repeat (2) @(negedge clk);
        checkOutput("resetA", {gnt0, gnt1, ack0, ack1, sel, memEn, memWe}, 32'd0);
        checkOutput("resetAbus", {memAddr, rdata}, 32'd0);
        checkOutput("resetB", {bGnt1, bAck1, bSel, bMemEn, bMemWe}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read at MEM_LAT=1.
        applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0);
        @(negedge clk);
        checkOutput("readGrant", {gnt0, gnt1, memEn, sel}, 32'b1010);
        checkOutput("readAddr", memAddr, 32'h0040);
        @(negedge clk);
        checkOutput("readNoEarlyAck", {ack0, memEn}, 32'd0);
        memRdata = 16'hBEEF;
        @(negedge clk);
        checkOutput("readAck", {ack0, ack1}, 32'b10);
        checkOutput("readData", rdata, 32'hBEEF);
        memRdata = 16'h1111;
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Write at MEM_LAT=3 on the second instance; rdata must not move.
        bReq1 = 1'b1; bWe1 = 1'b1; bAddr1 = 16'h0100; bWdata1 = 16'h1234;
        @(negedge clk);
        checkOutput("writeAccess", {bGnt1, bMemEn, bMemWe, bSel}, 32'b1111);
        checkOutput("writeBus", {bMemAddr, bMemWdata}, 32'h0100_1234);
        @(negedge clk);
        checkOutput("writeStrobeOnce", {bMemEn, bSel, bMemWe}, 32'b011);
        repeat (2) @(negedge clk);
        checkOutput("writeNoEarlyAck", bAck1, 32'd0);
        @(negedge clk);
        checkOutput("writeAck", {bAck1, bAck0}, 32'b10);
        checkOutput("writeRdata", bRdata, 32'h0);
        bReq1 = 1'b0;
        @(negedge clk);
        checkOutput("writeAckPulse", bAck1, 32'd0);

        // Requester changes its address after the grant.
        applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0);
        @(negedge clk);
        checkOutput("holdGrant", gnt0, 32'd1);
        addr0 = 16'h0080;
        @(negedge clk);
        checkOutput("holdAddrWait", memAddr, 32'h0040);
        @(negedge clk);
        checkOutput("holdAddrDone", {ack0, memAddr}, {15'd0, 1'b1, 16'h0040});
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Simultaneous requests, each requester drops on its own ack.
        resetDut();
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        waitFor("arbGrant1Timeout", 0, p);
        checkOutput("arbFirst", p, firstWin);
        checkOutput("arbFirstAddr", memAddr, firstWin == 1 ? 32'h0020 : 32'h0010);
        waitFor("arbAck1Timeout", 1, p);
        checkOutput("arbFirstAck", p, firstWin);
        applyStimulus(firstWin, 1'b0, 1'b0, 16'h0, 16'h0);
        waitFor("arbGrant2Timeout", 0, p);
        checkOutput("arbSecond", p, 1 - firstWin);
        waitFor("arbAck2Timeout", 1, p);
        checkOutput("arbSecondAck", p, 1 - firstWin);
        applyStimulus(1 - firstWin, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("arbNoRepeat", {gnt0, gnt1, ack0, ack1}, 32'd0);
        end

        // Both requests held for four accesses.
        resetDut();
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        for (int i = 0; i < 4; i++) begin
            waitFor("rrGrantTimeout", 0, p);
            checkOutput($sformatf("rrOrder%0d", i), p, rrExp[i]);
            waitFor("rrAckTimeout", 1, p);
            checkOutput($sformatf("rrAck%0d", i), p, rrExp[i]);
        end
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);

        // Reset asserted during WAIT of a port 0 read.
        resetDut();
        applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0);
        @(negedge clk);
        memRdata = 16'hBEEF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortCtl", {gnt0, gnt1, ack0, ack1, sel, memEn, memWe}, 32'd0);
        checkOutput("abortBus", {memAddr, memWdata}, 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        memRdata = 16'h1111;
        @(negedge clk);
        checkOutput("abortNoAck", ack0, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abortNoAckAfter", {ack0, gnt0, rdata}, 32'd0);
        end
        applyStimulus(0, 1'b1, 1'b0, 16'h0200, 16'h0);
        @(negedge clk);
        checkOutput("rereqGrant", {gnt0, memEn, memAddr}, {14'd0, 2'b11, 16'h0200});
        @(negedge clk);
        memRdata = 16'h5A5A;
        @(negedge clk);
        checkOutput("rereqAck", {ack0, rdata}, {15'd0, 1'b1, 16'h5A5A});
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
